// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared constants and status word layout for the UART transmit FIFO
package uart_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;

    // Bit positions in the IO status word read back by the harts
    localparam int STAT_LEVEL_LSB = 0;
    localparam int STAT_LEVEL_W   = 5;
    localparam int STAT_FULL_BIT  = 8;
    localparam int STAT_BUSY_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    typedef struct packed {
        logic       en;
        logic [7:0] data;
    } wr_slot_t;

    function automatic logic [31:0] status_word(
        input logic [STAT_LEVEL_W-1:0] level,
        input logic                    full,
        input logic                    empty,
        input logic                    ovf
    );
        logic [31:0] w;
        w = '0;
        w[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        w[STAT_FULL_BIT] = full;
        w[STAT_BUSY_BIT] = !empty;
        w[STAT_OVF_BIT]  = ovf;
        return w;
    endfunction

endpackage

// File: rtl/fifo_rr_arb.sv
// rtl/fifo_rr_arb.sv - round-robin ordering of the two writers into at most two FIFO slots
module fifo_rr_arb
    import uart_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       a_wr,
    input  logic [7:0] a_data,
    input  logic       b_wr,
    input  logic [7:0] b_data,
    input  logic       free_ge1,
    input  logic       free_ge2,
    output wr_slot_t   slot0,
    output wr_slot_t   slot1,
    output logic [1:0] push_cnt,
    output logic       drop
);

    logic rr_q;
    logic rr_d;
    logic both;

    assign both = a_wr & b_wr;
    assign rr_d = both ? !rr_q : rr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Capacity is judged on the start-of-cycle level only, so acceptance never depends on out_ready
    always_comb begin
        slot0    = '0;
        slot1    = '0;
        push_cnt = 2'd0;
        drop     = 1'b0;
        if (both) begin
            slot0.data = rr_q ? b_data : a_data;
            slot1.data = rr_q ? a_data : b_data;
            slot0.en   = free_ge1;
            slot1.en   = free_ge2;
            push_cnt   = free_ge2 ? 2'd2 : (free_ge1 ? 2'd1 : 2'd0);
            drop       = !free_ge2;
        end else if (a_wr || b_wr) begin
            slot0.data = a_wr ? a_data : b_data;
            slot0.en   = free_ge1;
            push_cnt   = free_ge1 ? 2'd1 : 2'd0;
            drop       = !free_ge1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - dual-writer byte FIFO feeding the UART emitter over valid/ready
module uart_tx_fifo
    import uart_fifo_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_wr,
    input  logic [7:0]    a_data,
    input  logic          b_wr,
    input  logic [7:0]    b_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW:0] DEPTH_M1  = (AW+1)'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;

    wr_slot_t      slot0, slot1;
    logic [1:0]    push_cnt;
    logic          drop;
    logic          pop;
    logic          free_ge1, free_ge2;

    assign free_ge1 = level_q < DEPTH_L;
    assign free_ge2 = level_q < DEPTH_M1;

    fifo_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .a_wr     (a_wr),
        .a_data   (a_data),
        .b_wr     (b_wr),
        .b_data   (b_data),
        .free_ge1 (free_ge1),
        .free_ge2 (free_ge2),
        .slot0    (slot0),
        .slot1    (slot1),
        .push_cnt (push_cnt),
        .drop     (drop)
    );

    assign empty     = level_q == '0;
    assign full      = level_q == DEPTH_L;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_cnt);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push_cnt) - (AW+1)'(pop);
        // A drop in the same cycle as a clear keeps the flag set
        ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (slot0.en) begin
                mem_q[wr_ptr_q] <= slot0.data;
            end
            if (slot1.en) begin
                mem_q[wr_ptr_q + AW'(1)] <= slot1.data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_wr = 1'b0, b_wr = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic [7:0] out_data;
    logic       out_valid, full, empty, overflow;
    logic [4:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_wr      (a_wr),
        .a_data    (a_data),
        .b_wr      (b_wr),
        .b_data    (b_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the arbitration flag and sticky overflow
    logic [7:0] mq[$];
    bit         m_rr;
    bit         m_ovf;
    int         m_drops;

    typedef struct {
        bit         aw;
        logic [7:0] ad;
        bit         bw;
        logic [7:0] bd;
        bit         rdy;
        bit         clr;
        int         lvl;
        bit         vld;
        logic [7:0] dat;
        bit         ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr  = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit aw, input logic [7:0] ad, input bit bw,
                              input logic [7:0] bd, input bit rdy, input bit clr);
        int         free;
        bit         popped;
        bit         dropped;
        logic [7:0] acc[$];
        free    = DEPTH - mq.size();
        popped  = (mq.size() > 0) && rdy;
        dropped = 1'b0;
        if (aw && bw) begin
            if (free >= 1) acc.push_back(m_rr ? bd : ad);
            else           dropped = 1'b1;
            if (free >= 2) acc.push_back(m_rr ? ad : bd);
            else           dropped = 1'b1;
            m_rr = !m_rr;
        end else if (aw || bw) begin
            if (free >= 1) acc.push_back(aw ? ad : bd);
            else           dropped = 1'b1;
        end
        if (dropped) m_drops++;
        if (popped) void'(mq.pop_front());
        foreach (acc[i]) mq.push_back(acc[i]);
        if (dropped)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic step(input bit aw, input logic [7:0] ad, input bit bw,
                        input logic [7:0] bd, input bit rdy, input bit clr);
        a_wr = aw; a_data = ad; b_wr = bw; b_data = bd;
        out_ready = rdy; ovf_clr = clr;
        model_step(aw, ad, bw, bd, rdy, clr);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(mq.size()));
        chk({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, "_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk({tag, "_data"}, 32'(out_data), 32'(mq[0]));
    endtask

    task automatic add(input bit aw, input logic [7:0] ad, input bit bw, input logic [7:0] bd,
                       input bit rdy, input bit clr, input int lvl, input bit vld,
                       input logic [7:0] dat, input bit ovf);
        vec_t v;
        v.aw = aw; v.ad = ad; v.bw = bw; v.bd = bd; v.rdy = rdy; v.clr = clr;
        v.lvl = lvl; v.vld = vld; v.dat = dat; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] ord[16];
        int         thr;

        // Basic write/drain, paired writes to full, overflow and clear
        add(1, 8'h41, 0, 8'h00, 1, 0, 1, 1, 8'h41, 0);
        add(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            add(1, 8'(8'h30 + i), 1, 8'(8'h61 + i), 0, 0, 2 * (i + 1), 1, 8'h30, 0);
            ord[2*i]   = (i % 2 == 0) ? 8'(8'h30 + i) : 8'(8'h61 + i);
            ord[2*i+1] = (i % 2 == 0) ? 8'(8'h61 + i) : 8'(8'h30 + i);
        end
        add(1, 8'h5A, 0, 8'h00, 0, 0, 16, 1, 8'h30, 1);
        add(0, 8'h00, 0, 8'h00, 0, 1, 16, 1, 8'h30, 0);
        for (int k = 1; k <= 16; k++) begin
            add(0, 8'h00, 0, 8'h00, 1, 0, 16 - k, k < 16, (k < 16) ? ord[k % 16] : 8'h00, 0);
        end

        model_reset();
        m_drops = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        reset = 1'b0;
        @(negedge clk);

        foreach (tbl[r]) begin
            step(tbl[r].aw, tbl[r].ad, tbl[r].bw, tbl[r].bd, tbl[r].rdy, tbl[r].clr);
            chk($sformatf("vec%0d_level", r), 32'(level), 32'(tbl[r].lvl));
            chk($sformatf("vec%0d_full", r), 32'(full), 32'(tbl[r].lvl == 16));
            chk($sformatf("vec%0d_empty", r), 32'(empty), 32'(tbl[r].lvl == 0));
            chk($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(tbl[r].vld));
            chk($sformatf("vec%0d_ovf", r), 32'(overflow), 32'(tbl[r].ovf));
            if (tbl[r].vld) chk($sformatf("vec%0d_data", r), 32'(out_data), 32'(tbl[r].dat));
        end

        // Level 15 with rr=1: B wins the last slot, A is dropped, a pop keeps level at 15
        step(1, 8'hA0, 1, 8'hB0, 0, 0);
        check_model("t4_pair");
        for (int i = 0; i < 13; i++) begin
            step(1, 8'(8'h80 + i), 0, 8'h00, 0, 0);
        end
        check_model("t4_fill");
        chk("t4_pre_level", 32'(level), 32'd15);
        step(1, 8'hAA, 1, 8'hBB, 1, 0);
        chk("t4_level", 32'(level), 32'd15);
        chk("t4_ovf", 32'(overflow), 32'd1);
        check_model("t4_race");
        for (int i = 0; i < 14; i++) begin
            step(0, 8'h00, 0, 8'h00, 1, 0);
            check_model("t4_drain");
        end
        chk("t4_tail", 32'(out_data), 32'hBB);
        step(0, 8'h00, 0, 8'h00, 1, 1);
        check_model("t4_clr");

        // Pointer wrap: 40 writes with a pop only every third cycle
        m_drops = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 8'($urandom), 0, 8'h00, (i % 3) == 2, 0);
            check_model("t5_stream");
        end
        chk("t5_dropped", 32'(m_drops > 0), 32'(overflow));
        for (int i = 0; i < 18; i++) begin
            step(0, 8'h00, 0, 8'h00, 1, 0);
            check_model("t5_drain");
        end

        // Asynchronous reset with 5 bytes buffered and overflow set
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h00, 1, 8'(8'hE0 + i), 0, 0);
        end
        check_model("t6_pre");
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_data", 32'(out_data), 32'h00);
        a_wr = 1'b0; b_wr = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1, 8'hC3, 0, 8'h00, 0, 0);
        chk("t6_first", 32'(out_data), 32'hC3);
        check_model("t6_post");

        // Randomised traffic with drain pressure varying per block
        for (int blk = 0; blk < 4; blk++) begin
            thr = (blk == 0) ? 20 : (blk == 2) ? 85 : 50;
            for (int i = 0; i < 100; i++) begin
                step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
                     $urandom_range(0, 99) < thr, $urandom_range(0, 15) == 0);
                check_model("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
